// File: rtl/gyruss_sndcmd_tx_if.sv
// Command path between the main CPU bus decode and the sound-board request lines.
// The master side writes commands; the slave side (transmitter) drives the request and status.
interface gyruss_sndcmd_tx_if #(
    parameter int AW = 2
);
    logic        WR;
    logic [7:0]  WDATA;
    logic        CLR;
    logic        SNDRQ;
    logic [7:0]  SNDNO;
    logic        BUSY;
    logic        EMPTY;
    logic        FULL;
    logic [AW:0] LEVEL;
    logic        OVF;

    modport master (
        output WR, WDATA, CLR,
        input  SNDRQ, SNDNO, BUSY, EMPTY, FULL, LEVEL, OVF
    );

    modport slave (
        input  WR, WDATA, CLR,
        output SNDRQ, SNDNO, BUSY, EMPTY, FULL, LEVEL, OVF
    );
endinterface

// File: rtl/gyruss_sndcmd_tx.sv
// Buffers CPU sound commands in a small FIFO and presents each one on SNDNO/SNDRQ
// with fixed setup, pulse-width and gap so the sound board latches it exactly once.
module gyruss_sndcmd_tx #(
    parameter int AW    = 2,
    parameter int SETUP = 4,
    parameter int HOLD  = 32,
    parameter int GAP   = 32
) (
    input logic              MCLK,
    input logic              RESET,
    gyruss_sndcmd_tx_if.slave bus
);
    localparam int DEPTH  = 1 << AW;
    localparam int MAX_SH = (SETUP > HOLD) ? SETUP : HOLD;
    localparam int MAXLEN = (MAX_SH > GAP) ? MAX_SH : GAP;
    localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          sndrq_q, sndrq_d;
    logic [7:0]    sndno_q, sndno_d;
    logic          busy_q, busy_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [DEPTH];
    logic          pop;
    logic          push;

    always_comb begin
        pop  = (state_q == S_IDLE) && (count_q != '0) && !bus.CLR;
        // A full FIFO still accepts a write when the head leaves on the same edge.
        push = bus.WR && !bus.CLR && ((count_q < (AW+1)'(DEPTH)) || pop);

        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sndrq_d  = sndrq_q;
        sndno_d  = sndno_q;
        ovf_d    = ovf_q;

        if (bus.CLR) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (bus.WR && !push) ovf_d = 1'b1;
        end

        // CLR leaves the sequencer alone so an in-flight pulse always completes.
        case (state_q)
            S_IDLE: begin
                sndrq_d = 1'b0;
                if (pop) begin
                    sndno_d = mem_q[rd_ptr_q];
                    cnt_d   = CW'(SETUP - 1);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = CW'(HOLD - 1);
                    sndrq_d = 1'b1;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    cnt_d   = CW'(GAP - 1);
                    sndrq_d = 1'b0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                sndrq_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        empty_d = (count_d == '0);
        full_d  = (count_d == (AW+1)'(DEPTH));
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sndrq_q  <= 1'b0;
            sndno_q  <= 8'h00;
            busy_q   <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sndrq_q  <= sndrq_d;
            sndno_q  <= sndno_d;
            busy_q   <= busy_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge MCLK) begin
        if (push) mem_q[wr_ptr_q] <= bus.WDATA;
    end

    assign bus.SNDRQ = sndrq_q;
    assign bus.SNDNO = sndno_q;
    assign bus.BUSY  = busy_q;
    assign bus.EMPTY = empty_q;
    assign bus.FULL  = full_q;
    assign bus.LEVEL = count_q;
    assign bus.OVF   = ovf_q;
endmodule
